// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe: decode-side input beat, flush and the extended-immediate output.
// master = upstream/consumer side driving the unit, slave = the unit itself.
interface imm_ext_pipe_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     Instr;
  logic [2:0]      ImmSrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ImmExt;
  logic            out_illegal;

  modport master (
    output flush, in_valid, Instr, ImmSrc, out_ready,
    input  in_ready, out_valid, ImmExt, out_illegal
  );

  modport slave (
    input  flush, in_valid, Instr, ImmSrc, out_ready,
    output in_ready, out_valid, ImmExt, out_illegal
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered RISC-V immediate extender with valid/ready output stage and optional skid entry.
// Define IMM_AUTODECODE_EN to derive the format from the opcode instead of ImmSrc.
module imm_ext_pipe #(
  parameter int XLEN      = 32,
  parameter bit SKID_EN_P = 1'b1
) (
  input logic          clk,
  input logic          reset,
  imm_ext_pipe_if.slave bus
);
  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_J     = 3'd3,
    FMT_U     = 3'd4,
    FMT_Z     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  fmt_e            w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_main_free;

  logic            r_main_valid;
  logic [XLEN-1:0] r_main_imm;
  logic            r_main_ill;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_imm;
  logic            r_skid_ill;

`ifdef IMM_AUTODECODE_EN
  logic w_unused_src;
  assign w_unused_src = ^bus.ImmSrc;

  always_comb begin
    w_fmt = FMT_ILL;
    case (bus.Instr[6:0])
      7'b0010011: w_fmt = (bus.Instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
      7'b0000011,
      7'b1100111: w_fmt = FMT_I;
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b1101111: w_fmt = FMT_J;
      7'b0110111,
      7'b0010111: w_fmt = FMT_U;
      7'b1110011: w_fmt = bus.Instr[14] ? FMT_Z : FMT_I;
      default:    w_fmt = FMT_ILL;
    endcase
  end
`else
  logic w_unused_op;
  assign w_unused_op = ^bus.Instr[6:0];
  assign w_fmt       = fmt_e'(bus.ImmSrc);
`endif

  // Signed casts of the assembled fields give sign extension from Instr[31] to XLEN.
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (w_fmt)
      FMT_I:     w_imm = XLEN'($signed(bus.Instr[31:20]));
      FMT_S:     w_imm = XLEN'($signed({bus.Instr[31:25], bus.Instr[11:7]}));
      FMT_B:     w_imm = XLEN'($signed({bus.Instr[31], bus.Instr[7], bus.Instr[30:25],
                                        bus.Instr[11:8], 1'b0}));
      FMT_J:     w_imm = XLEN'($signed({bus.Instr[31], bus.Instr[19:12], bus.Instr[20],
                                        bus.Instr[30:21], 1'b0}));
      FMT_U:     w_imm = XLEN'($signed({bus.Instr[31:12], 12'b0}));
      FMT_Z:     w_imm = XLEN'(bus.Instr[19:15]);
      FMT_SHAMT: w_imm = (XLEN == 64) ? XLEN'(bus.Instr[25:20]) : XLEN'(bus.Instr[24:20]);
      default:   w_ill = 1'b1;
    endcase
  end

  // With the skid entry, in_ready is a pure register output so upstream never sees out_ready.
  assign w_in_ready  = SKID_EN_P ? !r_skid_valid : (!r_main_valid || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
  assign w_main_free = !r_main_valid || bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_ill   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_ill   <= 1'b0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= r_skid_imm;
        r_main_ill   <= r_skid_ill;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main_imm <= w_imm;
          r_main_ill <= w_ill;
        end
      end
    end else if (w_accept && SKID_EN_P) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_ill   <= w_ill;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_main_valid;
  assign bus.ImmExt      = r_main_imm;
  assign bus.out_illegal = r_main_ill;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a 32-bit skid build and a 64-bit single-register build share one
// stimulus stream; each is checked every cycle against a queue-based reference model.
module tb_imm_ext_pipe;
  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr     = 32'd0;
  logic [2:0]  imm_src   = 3'd0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  logic [63:0] tap_imm [2];
  logic        tap_vld [2];
  logic        tap_rdy [2];
  logic        tap_ill [2];

  always #5 clk = ~clk;

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = ~64'd0 << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  function automatic logic [2:0] eff_src(input logic [31:0] ins, input logic [2:0] src);
`ifdef IMM_AUTODECODE_EN
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    if (op == 7'h13) return (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
    if (op == 7'h03 || op == 7'h67) return 3'd0;
    if (op == 7'h23) return 3'd1;
    if (op == 7'h63) return 3'd2;
    if (op == 7'h6F) return 3'd3;
    if (op == 7'h37 || op == 7'h17) return 3'd4;
    if (op == 7'h73) return f3[2] ? 3'd5 : 3'd0;
    return 3'd7;
`else
    if (ins == 32'hDEADBEEF) return 3'd7;
    return src;
`endif
  endfunction

  function automatic exp_t imm_ref(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    exp_t e;
    e = '0;
    case (eff_src(ins, src))
      3'd0: e.imm = sext(64'(ins[31:20]), 12);
      3'd1: e.imm = sext(64'({ins[31:25], ins[11:7]}), 12);
      3'd2: e.imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      3'd3: e.imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      3'd4: e.imm = sext(64'({ins[31:12], 12'd0}), 32);
      3'd5: e.imm = 64'(ins[19:15]);
      3'd6: e.imm = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: e.ill = 1'b1;
    endcase
    if (xlen == 32) e.imm[63:32] = 32'd0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int XW = (gi == 0) ? 32 : 64;
    localparam bit SK = (gi == 0);

    imm_ext_pipe_if #(.XLEN(XW)) bus ();

    assign bus.flush     = flush;
    assign bus.in_valid  = in_valid;
    assign bus.Instr     = instr;
    assign bus.ImmSrc    = imm_src;
    assign bus.out_ready = out_ready;

    imm_ext_pipe #(.XLEN(XW), .SKID_EN_P(SK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign tap_imm[gi] = 64'(bus.ImmExt);
    assign tap_vld[gi] = bus.out_valid;
    assign tap_rdy[gi] = bus.in_ready;
    assign tap_ill[gi] = bus.out_illegal;

    // Reference: a FIFO of extended values; capacity 2 with skid, else 1 with pass-through.
    exp_t q[$];
    logic m_rdy, m_acc, m_drn;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        q.delete();
      end else begin
        m_rdy = SK ? (q.size() < 2) : (q.size() == 0 || out_ready);
        m_acc = in_valid && m_rdy && !flush;
        m_drn = (q.size() > 0) && out_ready;
        if (flush) begin
          q.delete();
        end else begin
          if (m_drn) void'(q.pop_front());
          if (m_acc) q.push_back(imm_ref(instr, imm_src, XW));
        end
      end
    end

    always @(negedge clk) begin
      if (!reset) begin
        chk($sformatf("x%0d out_valid", XW), 64'(tap_vld[gi]), 64'(q.size() > 0));
        chk($sformatf("x%0d in_ready", XW), 64'(tap_rdy[gi]),
            64'(SK ? (q.size() < 2) : (q.size() == 0 || out_ready)));
        if (q.size() > 0) begin
          chk($sformatf("x%0d ImmExt", XW), tap_imm[gi], q[0].imm);
          chk($sformatf("x%0d out_illegal", XW), 64'(tap_ill[gi]), 64'(q[0].ill));
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [2:0] src,
                     input logic fl, input logic ordy);
    in_valid  = v;
    instr     = ins;
    imm_src   = src;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("reset out_valid", 64'(tap_vld[0]), 64'd0);
    chk("reset ImmExt", tap_imm[0], 64'd0);
    chk("reset out_illegal", 64'(tap_ill[0]), 64'd0);
    chk("reset in_ready", 64'(tap_rdy[0]), 64'd1);

    chk("model B", imm_ref(32'hFE000EE3, 3'd2, 32).imm, 64'h00000000FFFFFFFC);
    chk("model J", imm_ref(32'h0080006F, 3'd3, 32).imm, 64'h0000000000000008);
    chk("model U64", imm_ref(32'h800000B7, 3'd4, 64).imm, 64'hFFFFFFFF80000000);

    cyc(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b1);
    chk("I x32 ImmExt", tap_imm[0], 64'h00000000FFFFFFFF);
    chk("I x32 out_valid", 64'(tap_vld[0]), 64'd1);
    cyc(1'b1, 32'hFE000EE3, 3'd2, 1'b0, 1'b1);
    chk("B x32 ImmExt", tap_imm[0], 64'h00000000FFFFFFFC);
    cyc(1'b1, 32'h0080006F, 3'd3, 1'b0, 1'b1);
    chk("J x32 ImmExt", tap_imm[0], 64'h0000000000000008);
    cyc(1'b1, 32'h800000B7, 3'd4, 1'b0, 1'b1);
    chk("U x64 ImmExt", tap_imm[1], 64'hFFFFFFFF80000000);
    cyc(1'b1, 32'hFFFFFFFF, 3'd7, 1'b0, 1'b1);
    chk("illegal x64 ImmExt", tap_imm[1], 64'd0);
    chk("illegal x64 out_illegal", 64'(tap_ill[1]), 64'd1);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

    // Stall with three back-to-back beats: A=1, B=2, C=3.
    cyc(1'b1, 32'h00100093, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00200093, 3'd0, 1'b0, 1'b0);
    chk("skid in_ready low", 64'(tap_rdy[0]), 64'd0);
    cyc(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b0);
    chk("skid hold A", tap_imm[0], 64'd1);
    cyc(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b1);
    chk("skid out B", tap_imm[0], 64'd2);
    cyc(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b1);
    chk("skid out C", tap_imm[0], 64'd3);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

    cyc(1'b1, 32'h00100093, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00200093, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00300093, 3'd0, 1'b1, 1'b0);
    chk("flush out_valid", 64'(tap_vld[0]), 64'd0);
    chk("flush in_ready", 64'(tap_rdy[0]), 64'd1);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
    chk("post-flush out_valid", 64'(tap_vld[0]), 64'd0);

    cyc(1'b1, 32'h00500093, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async reset x32 out_valid", 64'(tap_vld[0]), 64'd0);
    chk("async reset x32 ImmExt", tap_imm[0], 64'd0);
    chk("async reset x32 in_ready", 64'(tap_rdy[0]), 64'd1);
    chk("async reset x64 out_valid", 64'(tap_vld[1]), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    repeat (3000) begin
      cyc($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
          $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
    end
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
